// File: rtl/fp_operand_unpack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants for the binary32 operand unpack stage:
//                operand class codes, FSM state encoding, IEEE limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Operand classes presented on a_class / b_class
    localparam logic [2:0] FP_ZERO   = 3'd0;
    localparam logic [2:0] FP_DENORM = 3'd1;
    localparam logic [2:0] FP_NORMAL = 3'd2;
    localparam logic [2:0] FP_INF    = 3'd3;
    localparam logic [2:0] FP_QNAN   = 3'd4;
    localparam logic [2:0] FP_SNAN   = 3'd5;

    // Unpack controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // binary32 exponent limits
    localparam int EXP_MAX = 255;
    localparam int BIAS    = 127;

endpackage
`default_nettype wire

// File: rtl/fp_operand_unpack_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_field_classify
//  Description : Combinational decode of one IEEE word into sign, class,
//                initial extended exponent and initial 24-bit mantissa.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_field_classify
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int XEXP_W = 10
) (
    input  logic [EXP_W+FRAC_W:0] word_i,
    output logic                  sign_o,
    output logic [2:0]            class_o,
    output logic [XEXP_W-1:0]     exp_o,
    output logic [FRAC_W:0]       mant_o
);

    localparam logic [EXP_W-1:0] c_EXP_ALL1 = '1;

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;

    assign sign_o = word_i[EXP_W+FRAC_W];
    assign w_exp  = word_i[EXP_W+FRAC_W-1:FRAC_W];
    assign w_frac = word_i[FRAC_W-1:0];

    // Classify; denormals start at exponent 1 with no hidden bit so the
    // shift loop can bring them to the normal form.
    always_comb begin
        class_o = FP_ZERO;
        exp_o   = '0;
        mant_o  = '0;
        if (w_exp == '0) begin
            if (w_frac != '0) begin
                class_o = FP_DENORM;
                exp_o   = XEXP_W'(1);
                mant_o  = {1'b0, w_frac};
            end
        end else begin
            exp_o  = {{(XEXP_W-EXP_W){1'b0}}, w_exp};
            mant_o = {1'b1, w_frac};
            if (w_exp != c_EXP_ALL1) begin
                class_o = FP_NORMAL;
            end else if (w_frac == '0) begin
                class_o = FP_INF;
            end else if (w_frac[FRAC_W-1]) begin
                class_o = FP_QNAN;
            end else begin
                class_o = FP_SNAN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_operand_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_operand_unpack
//  Description : Accepts a binary32 operand pair, classifies both, normalises
//                denormals one bit per cycle and presents unpacked operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int XEXP_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    a_sign,
    output logic                    b_sign,
    output logic [XEXP_W-1:0]       a_exp,
    output logic [XEXP_W-1:0]       b_exp,
    output logic [FRAC_W:0]         a_mant,
    output logic [FRAC_W:0]         b_mant,
    output logic [2:0]              a_class,
    output logic [2:0]              b_class
);

    state_e              state_q, state_d;
    logic                a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [XEXP_W-1:0]   a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [FRAC_W:0]     a_mant_q, a_mant_d, b_mant_q, b_mant_d;
    logic [2:0]          a_class_q, a_class_d, b_class_q, b_class_d;

    logic                w_a_sign, w_b_sign;
    logic [2:0]          w_a_class, w_b_class;
    logic [XEXP_W-1:0]   w_a_exp, w_b_exp;
    logic [FRAC_W:0]     w_a_mant, w_b_mant;
    logic                w_accept, w_any_denorm;
    logic                w_a_shift, w_b_shift, w_a_done, w_b_done;

    fp_field_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .XEXP_W(XEXP_W)) u_cls_a (
        .word_i (a),
        .sign_o (w_a_sign),
        .class_o(w_a_class),
        .exp_o  (w_a_exp),
        .mant_o (w_a_mant)
    );

    fp_field_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .XEXP_W(XEXP_W)) u_cls_b (
        .word_i (b),
        .sign_o (w_b_sign),
        .class_o(w_b_class),
        .exp_o  (w_b_exp),
        .mant_o (w_b_mant)
    );

    // A consumed result frees the stage in the same cycle, so OUT can accept
    assign in_ready     = (state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready);
    assign out_valid    = (state_q == ST_OUT);
    assign w_accept     = in_valid & in_ready;
    assign w_any_denorm = (w_a_class == FP_DENORM) | (w_b_class == FP_DENORM);

    // An operand still shifting is a denormal without its leading 1; it is
    // done after this cycle if the bit moving into the MSB is set.
    assign w_a_shift = (a_class_q == FP_DENORM) & ~a_mant_q[FRAC_W];
    assign w_b_shift = (b_class_q == FP_DENORM) & ~b_mant_q[FRAC_W];
    assign w_a_done  = ~w_a_shift | a_mant_q[FRAC_W-1];
    assign w_b_done  = ~w_b_shift | b_mant_q[FRAC_W-1];

    assign a_sign  = a_sign_q;
    assign b_sign  = b_sign_q;
    assign a_exp   = a_exp_q;
    assign b_exp   = b_exp_q;
    assign a_mant  = a_mant_q;
    assign b_mant  = b_mant_q;
    assign a_class = a_class_q;
    assign b_class = b_class_q;

    // Next state and datapath: hold, normalise, or load a newly accepted pair
    always_comb begin
        state_d   = state_q;
        a_sign_d  = a_sign_q;
        b_sign_d  = b_sign_q;
        a_exp_d   = a_exp_q;
        b_exp_d   = b_exp_q;
        a_mant_d  = a_mant_q;
        b_mant_d  = b_mant_q;
        a_class_d = a_class_q;
        b_class_d = b_class_q;

        case (state_q)
            ST_IDLE: ;
            ST_NORM: begin
                if (w_a_shift) begin
                    a_mant_d = {a_mant_q[FRAC_W-1:0], 1'b0};
                    a_exp_d  = a_exp_q - XEXP_W'(1);
                end
                if (w_b_shift) begin
                    b_mant_d = {b_mant_q[FRAC_W-1:0], 1'b0};
                    b_exp_d  = b_exp_q - XEXP_W'(1);
                end
                if (w_a_done & w_b_done) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept only happens in IDLE or OUT, so this never collides with NORM
        if (w_accept) begin
            a_sign_d  = w_a_sign;
            b_sign_d  = w_b_sign;
            a_exp_d   = w_a_exp;
            b_exp_d   = w_b_exp;
            a_mant_d  = w_a_mant;
            b_mant_d  = w_b_mant;
            a_class_d = w_a_class;
            b_class_d = w_b_class;
            state_d   = w_any_denorm ? ST_NORM : ST_OUT;
        end
    end

    // State and operand registers; reset discards any pair in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sign_q  <= 1'b0;
            b_sign_q  <= 1'b0;
            a_exp_q   <= '0;
            b_exp_q   <= '0;
            a_mant_q  <= '0;
            b_mant_q  <= '0;
            a_class_q <= FP_ZERO;
            b_class_q <= FP_ZERO;
        end else begin
            state_q   <= state_d;
            a_sign_q  <= a_sign_d;
            b_sign_q  <= b_sign_d;
            a_exp_q   <= a_exp_d;
            b_exp_q   <= b_exp_d;
            a_mant_q  <= a_mant_d;
            b_mant_q  <= b_mant_d;
            a_class_q <= a_class_d;
            b_class_q <= b_class_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_operand_unpack
//  Description : Scoreboard bench for fp_operand_unpack with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_operand_unpack;

    localparam logic [2:0] C_ZERO   = 3'd0;
    localparam logic [2:0] C_DENORM = 3'd1;
    localparam logic [2:0] C_NORMAL = 3'd2;
    localparam logic [2:0] C_INF    = 3'd3;
    localparam logic [2:0] C_QNAN   = 3'd4;
    localparam logic [2:0] C_SNAN   = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid;
    logic        a_sign, b_sign;
    logic [9:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;
    logic [2:0]  a_class, b_class;
    logic [75:0] w_act;

    fp_operand_unpack dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_sign   (a_sign),
        .b_sign   (b_sign),
        .a_exp    (a_exp),
        .b_exp    (b_exp),
        .a_mant   (a_mant),
        .b_mant   (b_mant),
        .a_class  (a_class),
        .b_class  (b_class)
    );

    assign w_act = {a_sign, a_exp, a_mant, a_class, b_sign, b_exp, b_mant, b_class};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [75:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [37:0] op(input logic s, input logic [9:0] e,
                                       input logic [23:0] m, input logic [2:0] c);
        return {s, e, m, c};
    endfunction

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Issue one pair; the expected result (and its visible cycle) is queued at accept
    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic [75:0] expd, input int lat, input bit push);
        bit ok;
        a = va;
        b = vb;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back('{expd, (lat < 0) ? -1 : cyc + lat - 1});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every completed output handshake must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h required none", w_act);
                end else begin
                    e = sb.pop_front();
                    check("result", w_act, e.data);
                    if (e.cyc >= 0) check("latency_cycle", 76'(cyc), 76'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [75:0] pi_exp;
        int          viol;

        // Reset state
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 76'(out_valid), 76'(0));
        check("reset_in_ready", 76'(in_ready), 76'(1));
        check("reset_data", w_act, 76'(0));
        step(1);

        // Normal pair, latency 1
        send(32'h3FC00000, 32'hC0000000,
             {op(0, 10'd127, 24'hC00000, C_NORMAL), op(1, 10'd128, 24'h800000, C_NORMAL)}, 1, 1);
        in_valid = 1'b0;
        step(3);

        // Worst-case denormal: 23 shifts, in_ready low throughout
        send(32'h00000001, 32'h3F800000,
             {op(0, 10'h3EA, 24'h800000, C_DENORM), op(0, 10'd127, 24'h800000, C_NORMAL)}, 24, 1);
        in_valid = 1'b0;
        viol = 0;
        repeat (23) begin
            @(negedge clk);
            if (in_ready) viol++;
        end
        check("in_ready_low_in_norm", 76'(viol), 76'(0));
        step(3);

        // Specials, latency 1 each
        send(32'h7F800000, 32'h7FC00000,
             {op(0, 10'd255, 24'h800000, C_INF), op(0, 10'd255, 24'hC00000, C_QNAN)}, 1, 1);
        send(32'h7F800001, 32'h80000000,
             {op(0, 10'd255, 24'h800001, C_SNAN), op(1, 10'd0, 24'h000000, C_ZERO)}, 1, 1);
        // Short denormal against zero, then two denormals shifting in parallel
        send(32'h00400000, 32'h00000000,
             {op(0, 10'd0, 24'h800000, C_DENORM), op(0, 10'd0, 24'h000000, C_ZERO)}, 2, 1);
        send(32'h80200000, 32'h00000003,
             {op(1, 10'h3FF, 24'h800000, C_DENORM), op(0, 10'h3EB, 24'hC00000, C_DENORM)}, 23, 1);
        in_valid = 1'b0;
        step(30);

        // Backpressure: result held for 5 cycles, then released with a new pair
        out_ready = 1'b0;
        pi_exp = {op(0, 10'd128, 24'hC90FDB, C_NORMAL), op(1, 10'd126, 24'h800000, C_NORMAL)};
        send(32'h40490FDB, 32'hBF000000, pi_exp, -1, 1);
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 76'(out_valid), 76'(1));
            check("bp_in_ready", 76'(in_ready), 76'(0));
            check("bp_hold", w_act, pi_exp);
        end
        step(1);
        out_ready = 1'b1;
        send(32'h41200000, 32'h3F800000,
             {op(0, 10'd130, 24'hA00000, C_NORMAL), op(0, 10'd127, 24'h800000, C_NORMAL)}, 1, 1);
        in_valid = 1'b0;
        step(3);

        // Reset on the 5th shift cycle discards the pair
        send(32'h00000001, 32'h00000000, 76'(0), -1, 0);
        in_valid = 1'b0;
        step(4);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midnorm_rst_out_valid", 76'(out_valid), 76'(0));
        check("midnorm_rst_in_ready", 76'(in_ready), 76'(1));
        check("midnorm_rst_data", w_act, 76'(0));
        step(1);
        rst = 1'b0;
        step(40);

        // Streaming: 8 back-to-back normal pairs
        send(32'h3F800000, 32'h40000000,
             {op(0, 10'd127, 24'h800000, C_NORMAL), op(0, 10'd128, 24'h800000, C_NORMAL)}, 1, 1);
        send(32'h40400000, 32'h40800000,
             {op(0, 10'd128, 24'hC00000, C_NORMAL), op(0, 10'd129, 24'h800000, C_NORMAL)}, 1, 1);
        send(32'hBF800000, 32'h3E800000,
             {op(1, 10'd127, 24'h800000, C_NORMAL), op(0, 10'd125, 24'h800000, C_NORMAL)}, 1, 1);
        send(32'h00800000, 32'h7F7FFFFF,
             {op(0, 10'd1, 24'h800000, C_NORMAL), op(0, 10'd254, 24'hFFFFFF, C_NORMAL)}, 1, 1);
        send(32'h41200000, 32'hC1200000,
             {op(0, 10'd130, 24'hA00000, C_NORMAL), op(1, 10'd130, 24'hA00000, C_NORMAL)}, 1, 1);
        send(32'h3DCCCCCD, 32'h42C80000,
             {op(0, 10'd123, 24'hCCCCCD, C_NORMAL), op(0, 10'd133, 24'hC80000, C_NORMAL)}, 1, 1);
        send(32'h447A0000, 32'h3F000000,
             {op(0, 10'd136, 24'hFA0000, C_NORMAL), op(0, 10'd126, 24'h800000, C_NORMAL)}, 1, 1);
        send(32'h40A00000, 32'hC0400000,
             {op(0, 10'd129, 24'hA00000, C_NORMAL), op(1, 10'd128, 24'hC00000, C_NORMAL)}, 1, 1);
        in_valid = 1'b0;
        step(5);

        check("scoreboard_drained", 76'(sb.size()), 76'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
